uart_tx_param: RTL

Parametrised UART transmitter replacing the fixed 8N1 transmitter in the serial output path. Adds configurable data width, baud divisor, parity mode and stop-bit count. Adds a small transmit FIFO so software-side logic can queue words while a frame is on the line. Consecutive queued words go out back-to-back with no idle gap.

---
 rtl/uart_tx_param_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 68 ++++++
 rtl/uart_tx_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_param_pkg.sv
// rtl/uart_tx_param_pkg.sv - shared types for the parametrised UART transmitter
package uart_tx_param_pkg;

    typedef logic bit_t;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_mode_e;

    // State names carry a prefix so they never collide with the PARITY parameter
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Initial parity accumulator value: odd parity starts inverted
    function automatic bit_t parity_seed(input parity_mode_e mode);
        return bit_t'(mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous word FIFO with registered full/empty/count
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;
    assign rdata   = mem[rd_ptr_q[AW-1:0]];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

    // Next pointers; the extra MSB tells full from empty when the indices match
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
        count_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Pointer and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with transmit FIFO
module uart_tx_param
    import uart_tx_param_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH   = 8,
    parameter int unsigned  CLKS_PER_BIT = 16,
    parameter parity_mode_e PARITY       = PARITY_NONE,
    parameter int unsigned  STOP_BITS    = 1,
    parameter int unsigned  FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          transmit,
    input  logic [DATA_WIDTH-1:0]         data,
    output logic                          ready,
    output logic                          serial_output,
    output logic                          busy,
    output logic                          baud_tick,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
    localparam int unsigned FC_W  = $clog2(FIFO_DEPTH) + 1;

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    bit_t                  par_q, par_d;
    bit_t                  line_q, line_d;
    logic                  busy_q, busy_d;
    logic                  tick_q, tick_d;
    logic                  ovf_q, ovf_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  pop;
    logic                  load;
    logic                  tick;
    logic                  push_ok;
    logic [FC_W-1:0]       count_next;

    uart_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (transmit),
        .pop   (pop),
        .wdata (data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ready         = ~fifo_full;
    assign serial_output = line_q;
    assign busy          = busy_q;
    assign baud_tick     = tick_q;
    assign overflow      = ovf_q;

    assign tick    = (state_q != ST_IDLE) && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign push_ok = transmit && !fifo_full;

    // Frame sequencing: every state and bit advance waits for the end of a bit period
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == ST_IDLE || tick) ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        line_d  = line_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load = !fifo_empty;
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    line_d  = shreg_q[0];
                    par_d   = par_q ^ shreg_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        idx_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            line_d  = par_q;
                        end else begin
                            state_d = ST_STOP;
                            line_d  = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                        line_d  = shreg_q[1];
                        par_d   = par_q ^ shreg_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                    line_d  = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        load    = !fifo_empty;
                        state_d = ST_IDLE;
                        line_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = 1'b1;
            end
        endcase
        // A pop starts the next frame immediately so back-to-back words have no gap
        if (load) begin
            state_d = ST_START;
            cnt_d   = '0;
            shreg_d = fifo_rdata;
            par_d   = parity_seed(PARITY);
            line_d  = 1'b0;
        end
        pop        = load;
        count_next = fifo_count + FC_W'(push_ok) - FC_W'(pop);
        busy_d     = (state_d != ST_IDLE) || (count_next != '0);
        tick_d     = (state_d != ST_IDLE) && (cnt_d == CNT_W'(CLKS_PER_BIT - 1));
        ovf_d      = transmit && fifo_full;
    end

    // FSM and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
